// File: rtl/corelet_pkg.sv
// corelet_pkg: sequencer state encoding and corelet instruction-word bit map
// shared by corelet_ctrl and anything that decodes its inst output.
package corelet_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_L0,
        S_W_LOAD,
        S_W_FLUSH,
        S_X_L0,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int unsigned INST_KLOAD    = 0;
    localparam int unsigned INST_EXEC     = 1;
    localparam int unsigned INST_L0_WR    = 2;
    localparam int unsigned INST_L0_RD    = 3;
    localparam int unsigned INST_OFIFO_RD = 6;
    localparam int unsigned INST_W        = 34;

endpackage

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: per-layer weight-stationary sequencer driving corelet inst, xmem reads and pmem writes.
// Optional CORELET_CTRL_ABORT_EN adds an abort input that returns the FSM to IDLE without a done pulse.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned len_kij = 9,
    parameter int unsigned len_nij = 36,
    parameter int unsigned w_base  = 11'd1024,
    parameter int unsigned addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef CORELET_CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic               ofifo_valid,
    output logic               busy,
    output logic               done,
    output logic [INST_W-1:0]  inst,
    output logic               xmem_cen,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               pmem_wen,
    output logic [addr_bw-1:0] pmem_addr
);

    localparam int unsigned CW = 16;
    localparam int unsigned KW = 8;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       rows_q, rows_d;
    logic [KW-1:0]       kij_q, kij_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                xmem_cen_q, xmem_cen_d;
    logic [addr_bw-1:0]  xmem_addr_q, xmem_addr_d;
    logic                pmem_wen_q, pmem_wen_d;
    logic [addr_bw-1:0]  pmem_addr_q, pmem_addr_d;
    logic                abort_w;
    logic                rd;
    logic                last_wr;

`ifdef CORELET_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign rd      = (state_q == S_DRAIN) && ofifo_valid && (rows_q < CW'(len_nij));
    assign last_wr = (state_q == S_DRAIN) && !pmem_wen_q && (rows_q == CW'(len_nij));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        kij_d   = kij_q;
        rows_d  = rows_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_W_L0;
                    kij_d   = '0;
                end
            end
            S_W_L0:    if (cnt_q == CW'(col))           state_d = S_W_LOAD;
            S_W_LOAD:  if (cnt_q == CW'(col - 1))       state_d = S_W_FLUSH;
            S_W_FLUSH: if (cnt_q == CW'(row + col - 1)) state_d = S_X_L0;
            S_X_L0:    if (cnt_q == CW'(len_nij))       state_d = S_EXEC;
            S_EXEC: begin
                if (cnt_q == CW'(len_nij - 1)) begin
                    state_d = S_DRAIN;
                    rows_d  = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q;
                if (rd) rows_d = rows_q + CW'(1);
                if (last_wr) begin
                    if (kij_q == KW'(len_kij - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        kij_d   = kij_q + KW'(1);
                        state_d = S_W_L0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        // Abort also beats a simultaneous start while idle.
        if (abort_w) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Registered outputs are decoded from the upcoming state so they line up with state_q.
    always_comb begin
        inst_d      = '0;
        xmem_cen_d  = 1'b1;
        xmem_addr_d = xmem_addr_q;
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        case (state_d)
            S_W_L0: begin
                if (cnt_d < CW'(col)) begin
                    xmem_cen_d  = 1'b0;
                    xmem_addr_d = addr_bw'(w_base + col * 32'(kij_d) + 32'(cnt_d));
                end
                if (cnt_d != '0) inst_d[INST_L0_WR] = 1'b1;
            end
            S_W_LOAD: begin
                inst_d[INST_L0_RD] = 1'b1;
                inst_d[INST_KLOAD] = 1'b1;
            end
            S_X_L0: begin
                if (cnt_d < CW'(len_nij)) begin
                    xmem_cen_d  = 1'b0;
                    xmem_addr_d = addr_bw'(cnt_d);
                end
                if (cnt_d != '0) inst_d[INST_L0_WR] = 1'b1;
            end
            S_EXEC: begin
                inst_d[INST_L0_RD] = 1'b1;
                inst_d[INST_EXEC]  = 1'b1;
            end
            default: ;
        endcase
        pmem_wen_d  = !(rd && !abort_w);
        pmem_addr_d = (rd && !abort_w) ? addr_bw'(32'(kij_q) * len_nij + 32'(rows_q)) : pmem_addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rows_q      <= '0;
            kij_q       <= '0;
            inst_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            xmem_cen_q  <= 1'b1;
            xmem_addr_q <= '0;
            pmem_wen_q  <= 1'b1;
            pmem_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rows_q      <= rows_d;
            kij_q       <= kij_d;
            inst_q      <= inst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            xmem_cen_q  <= xmem_cen_d;
            xmem_addr_q <= xmem_addr_d;
            pmem_wen_q  <= pmem_wen_d;
            pmem_addr_q <= pmem_addr_d;
        end
    end

    // OFIFO read strobe follows this cycle's ofifo_valid so an empty FIFO is never popped.
    always_comb begin
        inst                = inst_q;
        inst[INST_OFIFO_RD] = rd;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign xmem_cen  = xmem_cen_q;
    assign xmem_addr = xmem_addr_q;
    assign pmem_wen  = pmem_wen_q;
    assign pmem_addr = pmem_addr_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: directed/randomized bench for corelet_ctrl against a cycle-timeline reference model.
// Exercises the abort port as well when CORELET_CTRL_ABORT_EN is defined.
module tb_corelet_ctrl;
    import corelet_pkg::*;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int KIJ  = 9;
    localparam int NIJ  = 36;
    localparam int WB   = 1024;
    localparam int AW   = 11;
    localparam int FIX  = (COL + 1) + COL + (ROW + COL) + (NIJ + 1) + NIJ;
    localparam int MAXC = 6000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ofifo_valid;
    logic          busy;
    logic          done;
    logic [33:0]   inst;
    logic          xmem_cen;
    logic [AW-1:0] xmem_addr;
    logic          pmem_wen;
    logic [AW-1:0] pmem_addr;
`ifdef CORELET_CTRL_ABORT_EN
    logic          abort = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    logic          vld_seq  [MAXC];
    logic [33:0]   exp_inst [MAXC];
    logic          exp_cen  [MAXC];
    logic [AW-1:0] exp_xa   [MAXC];
    logic          exp_wen  [MAXC];
    logic [AW-1:0] exp_pa   [MAXC];
    logic          exp_busy [MAXC];
    logic          exp_done [MAXC];
    logic [33:0]   rec_inst [MAXC];
    logic          rec_cen  [MAXC];
    logic [AW-1:0] rec_xa   [MAXC];
    logic          rec_wen  [MAXC];
    logic [AW-1:0] rec_pa   [MAXC];
    logic          rec_busy [MAXC];
    logic          rec_done [MAXC];

    always #5 clk = ~clk;

    corelet_ctrl #(
        .row(ROW), .col(COL), .len_kij(KIJ), .len_nij(NIJ), .w_base(WB), .addr_bw(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef CORELET_CTRL_ABORT_EN
        .abort(abort),
`endif
        .ofifo_valid(ofifo_valid),
        .busy(busy),
        .done(done),
        .inst(inst),
        .xmem_cen(xmem_cen),
        .xmem_addr(xmem_addr),
        .pmem_wen(pmem_wen),
        .pmem_addr(pmem_addr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_trace(input string tag, input int mism, input int first);
        tests++;
        assert (mism === 0) else begin
            fails++;
            $error("FAIL %s: observed %0d mismatching cycles (first at cycle %0d) expected 0", tag, mism, first);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
    task automatic tick(input logic s, input logic v);
        @(posedge clk);
        #1;
        start       = s;
        ofifo_valid = v;
        #1;
    endtask

    task automatic record(input int c);
        rec_inst[c] = inst;
        rec_cen[c]  = xmem_cen;
        rec_xa[c]   = xmem_addr;
        rec_wen[c]  = pmem_wen;
        rec_pa[c]   = pmem_addr;
        rec_busy[c] = busy;
        rec_done[c] = done;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_inst"}, inst, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_xcen"}, xmem_cen, 1);
        check({tag, "_xaddr"}, xmem_addr, 0);
        check({tag, "_pwen"}, pmem_wen, 1);
        check({tag, "_paddr"}, pmem_addr, 0);
    endtask

    // Cycle timeline of one layer; cycle 0 is the start cycle.
    task automatic build_model(output int donec);
        int t, d, reads, x0;
        for (int i = 0; i < MAXC; i++) begin
            exp_inst[i] = '0; exp_cen[i] = 1'b1; exp_xa[i] = '0; exp_wen[i] = 1'b1;
            exp_pa[i] = '0;   exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
        end
        t = 1;
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i < COL; i++) begin
                exp_cen[t + i] = 1'b0;
                exp_xa[t + i]  = AW'(WB + k * COL + i);
                exp_inst[t + i + 1][INST_L0_WR] = 1'b1;
                exp_inst[t + COL + 1 + i] = 34'h9;
            end
            x0 = t + (COL + 1) + COL + (ROW + COL);
            for (int i = 0; i < NIJ; i++) begin
                exp_cen[x0 + i] = 1'b0;
                exp_xa[x0 + i]  = AW'(i);
                exp_inst[x0 + i + 1][INST_L0_WR] = 1'b1;
                exp_inst[x0 + NIJ + 1 + i] = 34'ha;
            end
            d = t + FIX;
            reads = 0;
            while (reads < NIJ && d < MAXC - 2) begin
                if (vld_seq[d]) begin
                    exp_inst[d][INST_OFIFO_RD] = 1'b1;
                    exp_wen[d + 1] = 1'b0;
                    exp_pa[d + 1]  = AW'(k * NIJ + reads);
                    reads++;
                end
                d++;
            end
            t = d + 1;
        end
        donec = t;
        for (int i = 1; i < donec; i++) exp_busy[i] = 1'b1;
        exp_done[donec] = 1'b1;
    endtask

    // mode 0: ofifo_valid held high, 1: random, 2: toggling 1/0
    task automatic run_layer(input int mode, input bit stray, input string name);
        int donec, last, ndone, n9, nrd;
        int m_inst, m_cen, m_xa, m_wen, m_pa, m_busy, m_lag, m_rdv, m_ord;
        int f_inst, f_cen, f_xa, f_wen, f_pa, f_busy, f_lag, f_rdv, f_ord;
        int unsigned pq[$];
        int unsigned wq[$];
        for (int i = 0; i < MAXC; i++)
            vld_seq[i] = (mode == 0) ? 1'b1 : (mode == 2) ? ((i % 2) == 0) : ($urandom_range(0, 3) != 0);
        build_model(donec);
        tick(1'b1, vld_seq[0]);
        record(0);
        last = 1;
        while (1) begin
            tick(stray && (last == 50 || last == 500), vld_seq[last]);
            record(last);
            if (rec_done[last] || last >= donec + 20 || last >= MAXC - 3) break;
            last++;
        end
        start = 1'b0;
        check({name, "_done_cycle"}, last, donec);
        if (mode == 0) check({name, "_done_cycle_fixed"}, last, 1 + KIJ * (FIX + NIJ + 1));

        m_inst = 0; m_cen = 0; m_xa = 0; m_wen = 0; m_pa = 0; m_busy = 0; m_lag = 0; m_rdv = 0;
        f_inst = 0; f_cen = 0; f_xa = 0; f_wen = 0; f_pa = 0; f_busy = 0; f_lag = 0; f_rdv = 0;
        ndone = 0; n9 = 0; nrd = 0;
        for (int i = 0; i <= last; i++) begin
            if (rec_inst[i] !== exp_inst[i]) begin if (m_inst == 0) f_inst = i; m_inst++; end
            if (rec_cen[i] !== exp_cen[i]) begin if (m_cen == 0) f_cen = i; m_cen++; end
            if (!exp_cen[i] && rec_xa[i] !== exp_xa[i]) begin if (m_xa == 0) f_xa = i; m_xa++; end
            if (rec_wen[i] !== exp_wen[i]) begin if (m_wen == 0) f_wen = i; m_wen++; end
            if (!exp_wen[i] && rec_pa[i] !== exp_pa[i]) begin if (m_pa == 0) f_pa = i; m_pa++; end
            if (rec_busy[i] !== exp_busy[i] || rec_done[i] !== exp_done[i]) begin
                if (m_busy == 0) f_busy = i;
                m_busy++;
            end
            if (i > 0 && rec_inst[i][INST_L0_WR] !== !rec_cen[i - 1]) begin if (m_lag == 0) f_lag = i; m_lag++; end
            if (rec_inst[i][INST_OFIFO_RD] === 1'b1) begin
                nrd++;
                if (!vld_seq[i]) begin if (m_rdv == 0) f_rdv = i; m_rdv++; end
            end
            if (rec_done[i] === 1'b1) ndone++;
            if (rec_inst[i] === 34'h9) n9++;
            if (rec_wen[i] === 1'b0) pq.push_back(int'(rec_pa[i]));
            if (rec_cen[i] === 1'b0 && rec_xa[i] >= AW'(WB)) wq.push_back(int'(rec_xa[i]));
        end
        check_trace({name, "_inst_trace"}, m_inst, f_inst);
        check_trace({name, "_xcen_trace"}, m_cen, f_cen);
        check_trace({name, "_xaddr_trace"}, m_xa, f_xa);
        check_trace({name, "_pwen_trace"}, m_wen, f_wen);
        check_trace({name, "_paddr_trace"}, m_pa, f_pa);
        check_trace({name, "_busy_done_trace"}, m_busy, f_busy);
        check_trace({name, "_l0wr_lag"}, m_lag, f_lag);
        check_trace({name, "_rd_only_when_valid"}, m_rdv, f_rdv);
        check({name, "_done_pulses"}, ndone, 1);
        check({name, "_wload_cycles"}, n9, KIJ * COL);
        check({name, "_ofifo_reads"}, nrd, KIJ * NIJ);
        check({name, "_pmem_writes"}, pq.size(), KIJ * NIJ);
        m_ord = 0; f_ord = 0;
        for (int i = 0; i < pq.size(); i++)
            if (pq[i] != i) begin if (m_ord == 0) f_ord = i; m_ord++; end
        check_trace({name, "_pmem_order"}, m_ord, f_ord);
        check({name, "_w_reads"}, wq.size(), KIJ * COL);
        for (int i = 0; i < COL; i++)
            check({name, "_w_addr_kij2"}, (16 + i < wq.size()) ? wq[16 + i] : 0, 1040 + i);
    endtask

    task automatic idle_check(input string name, input int n);
        int hi;
        hi = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1);
            if (busy !== 1'b0 || done !== 1'b0 || inst !== '0) hi++;
        end
        check({name, "_stays_idle"}, hi, 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        reset = 1'b1;
        idle_check("post_reset", 10);

        run_layer(0, 1'b0, "valid_high");
        idle_check("after_layer1", 10);
        run_layer(2, 1'b1, "valid_toggle_stray_start");
        idle_check("after_layer2", 10);
        run_layer(1, 1'b0, "valid_random");
        idle_check("after_layer3", 10);

        // reset asserted in the middle of EXEC of the first kernel position
        tick(1'b1, 1'b1);
        for (int c = 1; c <= 80; c++) tick(1'b0, 1'b1);
        check("mid_exec_inst", inst, 34'ha);
        reset = 1'b0;
        #1;
        check_reset_vals("reset_async");
        @(posedge clk);
        #2;
        check_reset_vals("reset_held");
        reset = 1'b1;
        idle_check("after_mid_reset", 20);

`ifdef CORELET_CTRL_ABORT_EN
        tick(1'b1, 1'b1);
        for (int c = 1; c <= 40; c++) tick(1'b0, 1'b1);
        check("abort_pre_xcen", xmem_cen, 0);
        abort = 1'b1;
        tick(1'b0, 1'b1);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_inst", inst, 0);
        check("abort_xcen", xmem_cen, 1);
        check("abort_pwen", pmem_wen, 1);
        idle_check("after_abort", 1500);
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        #1;
        tick(1'b0, 1'b1);
        abort = 1'b0;
        check("abort_beats_start", busy, 0);
        idle_check("after_abort_start", 5);
        run_layer(0, 1'b0, "post_abort");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Sequencer that generates the corelet instruction word and the activation/weight SRAM (xmem) and psum SRAM (pmem) control signals for one weight-stationary convolution layer. For each kernel position kij it:
- loads the weights into L0 and then into the MAC array;
- streams the activations through the array;
- drains the output FIFO into pmem.

It sits between the testbench/host `start` handshake and the corelet/SRAM instances, replacing hand-written instruction vectors.

## Interface
Parameters:
- row, 8, MAC array rows (L0 width in words)
- col, 8, MAC array columns
- len_kij, 9, kernel positions per layer
- len_nij, 36, activation vectors per kernel position
- w_base, 11'd1024, xmem address of the first weight vector
- addr_bw, 11, xmem/pmem address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- ofifo_valid  in  1  corelet output FIFO holds a full row
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the layer completes
- inst  out  34  corelet instruction word (field map below)
- xmem_cen  out  1  active-low xmem chip enable (read only)
- xmem_addr  out  addr_bw  xmem read address
- pmem_wen  out  1  active-low pmem write enable
- pmem_addr  out  addr_bw  pmem write address

## Operation
inst field map (all other bits always 0):
- [0] kernel load
- [1] execute
- [2] L0 wr
- [3] L0 rd
- [6] OFIFO rd

All outputs are registered. Reset values:
- inst = 0, busy = 0, done = 0
- xmem_cen = 1, pmem_wen = 1
- addresses = 0
- state IDLE, counters 0

FSM states, with cnt cleared on every state entry:
- IDLE: inst = 0. start moves to W_L0; kij = 0.
- W_L0 (col+1 cycles):
  - cycles 0..col-1: xmem_cen = 0, xmem_addr = w_base + kij*col + cnt.
  - cycles 1..col: inst[2] = 1. xmem read latency is 1 cycle.
- W_LOAD (col cycles): inst[3] = 1, inst[0] = 1.
- W_FLUSH (row+col cycles): inst = 0, lets weights settle in the array.
- X_L0 (len_nij+1 cycles): same pattern as W_L0, with xmem_addr = cnt and inst[2] on cycles 1..len_nij.
- EXEC (len_nij cycles): inst[3] = 1, inst[1] = 1.
- DRAIN, until len_nij rows have been read:
  - inst[6] = 1 in any cycle where ofifo_valid = 1 and rows_read < len_nij.
  - The cycle after each read: pmem_wen = 0, pmem_addr = kij*len_nij + row index.
  - After the last write: if kij = len_kij-1 go to DONE, else kij++ and go to W_L0.
- DONE (1 cycle): done = 1, busy drops the same cycle, then IDLE.

Boundary conditions:
- start while busy is ignored.
- ofifo_valid outside DRAIN is ignored.
- DRAIN may overlap OFIFO filling that begins during EXEC; rows are counted only on reads.
- pmem_addr never exceeds len_kij*len_nij-1.
- Reset mid-operation returns to IDLE immediately and clears all outputs; no partial done pulse.

## Timing
- start sampled at edge t: state W_L0 and busy = 1 from t+1; first xmem read at t+1.
- Per-kij fixed overhead before DRAIN: (col+1) + col + (row+col) + (len_nij+1) + len_nij cycles. With defaults: 9+8+16+37+36 = 106.
- DRAIN length ≥ len_nij+1 cycles; with ofifo_valid held high it is exactly len_nij+1.
- done pulses exactly one cycle after the last pmem write.

## Configuration
- CORELET_CTRL_ABORT_EN: defined adds input port `abort` (1 bit).
  - abort = 1 in any non-IDLE state forces, at the next edge: state IDLE, inst = 0, xmem_cen = pmem_wen = 1, busy = 0.
  - No done pulse is issued for an aborted layer.
  - abort in IDLE has no effect; abort and start in the same IDLE cycle: abort wins, start is ignored.
- Undefined: the port is absent and the FSM always runs to completion.

## Structure
- Shared package corelet_pkg holds:
  - the state enum;
  - the inst bit-position constants (INST_KLOAD = 0, INST_EXEC = 1, INST_L0_WR = 2, INST_L0_RD = 3, INST_OFIFO_RD = 6, INST_W = 34).
- No sub-module required. The kij counter, cnt counter and rows_read counter live in the top.

## Test plan
- Reset: hold reset low mid-EXEC -> all outputs at reset values, FSM in IDLE; after release, busy stays 0 with no start.
- Single layer, ofifo_valid tied 1, defaults:
  - 9 × (106+37) cycles later done pulses once;
  - 324 pmem writes at addresses 0..323, in order.
- Weight phase kij = 2: xmem_addr sequence 1040..1047; inst[2] lags xmem_cen by 1 cycle; W_LOAD issues 8 cycles of inst = 34'h9.
- DRAIN stall: ofifo_valid toggles 1/0 -> inst[6] only on valid cycles; exactly 36 writes per kij; pmem_addr contiguous.
- start pulsed while busy -> ignored; second layer runs only after start in IDLE.
- With CORELET_CTRL_ABORT_EN: abort during X_L0 -> next cycle busy = 0, inst = 0, no done; a fresh start then completes normally.
